// File: rtl/output_read_scheduler.sv
// Round-robin read scheduler for the shared cell buffer output side.
// Tracks per-port pending cells and converter credits, grants one port per cycle.
module output_read_scheduler #(
  parameter int nbrOfPorts      = 4,
  parameter int addresses       = 256,
  parameter int creditDepth     = 4,
  parameter int nbrOfPortsWidth = $clog2(nbrOfPorts),
  parameter int countWidth      = $clog2(addresses) + 1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic [nbrOfPorts-1:0]      cellEnq,
  input  logic [nbrOfPorts-1:0]      creditReturn,
  input  logic [nbrOfPorts-1:0]      psFull,
  output logic                       readEnable,
  output logic [nbrOfPortsWidth-1:0] readPort,
  output logic [nbrOfPorts-1:0]      pendingEmpty,
  output logic                       errorOverflow,
  output logic                       errorCredit
);

  localparam int PW = nbrOfPortsWidth;
  localparam int CW = $clog2(creditDepth + 1);
  localparam logic [countWidth-1:0] PMAX = countWidth'(addresses);
  localparam logic [CW-1:0]         CMAX = CW'(creditDepth);
  localparam logic [PW-1:0]         LAST = PW'(nbrOfPorts - 1);
  localparam logic [PW:0]           NP   = (PW+1)'(nbrOfPorts);

  logic [countWidth-1:0] pending     [nbrOfPorts];
  logic [countWidth-1:0] pending_nxt [nbrOfPorts];
  logic [CW-1:0]         credit      [nbrOfPorts];
  logic [CW-1:0]         credit_nxt  [nbrOfPorts];

  logic [PW-1:0]         rr_ptr;
  logic [PW-1:0]         rr_nxt;
  logic [PW-1:0]         grant_port;
  logic                  grant_valid;
  logic [PW:0]           sum;
  logic [PW-1:0]         idx;
  logic [nbrOfPorts-1:0] elig;
  logic [nbrOfPorts-1:0] hit;
  logic [nbrOfPorts-1:0] ovf_hit;
  logic [nbrOfPorts-1:0] crd_hit;
  logic [nbrOfPorts-1:0] empty_nxt;

  always_comb begin
    for (int i = 0; i < nbrOfPorts; i++) begin
      elig[i] = (pending[i] != '0) && (credit[i] != '0)
                && !psFull[i] && enable;
    end
  end

  // first eligible port at or after rr_ptr, modulo nbrOfPorts
  always_comb begin
    grant_valid = 1'b0;
    grant_port  = '0;
    sum         = '0;
    idx         = '0;
    for (int k = 0; k < nbrOfPorts; k++) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= NP) sum = sum - NP;
      idx = sum[PW-1:0];
      if (!grant_valid && elig[idx]) begin
        grant_valid = 1'b1;
        grant_port  = idx;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < nbrOfPorts; i++) begin
      hit[i]         = grant_valid && (grant_port == PW'(i));
      pending_nxt[i] = pending[i];
      credit_nxt[i]  = credit[i];
      ovf_hit[i]     = 1'b0;
      crd_hit[i]     = 1'b0;
      if (cellEnq[i] && !hit[i]) begin
        if (pending[i] == PMAX) ovf_hit[i] = 1'b1;
        else pending_nxt[i] = pending[i] + countWidth'(1);
      end else if (!cellEnq[i] && hit[i]) begin
        pending_nxt[i] = pending[i] - countWidth'(1);
      end
      if (creditReturn[i] && !hit[i]) begin
        if (credit[i] == CMAX) crd_hit[i] = 1'b1;
        else credit_nxt[i] = credit[i] + CW'(1);
      end else if (!creditReturn[i] && hit[i]) begin
        credit_nxt[i] = credit[i] - CW'(1);
      end
      empty_nxt[i] = (pending_nxt[i] == '0);
    end
  end

  always_comb begin
    rr_nxt = rr_ptr;
    if (grant_valid) rr_nxt = (grant_port == LAST) ? '0 : grant_port + PW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < nbrOfPorts; i++) begin
        pending[i] <= '0;
        credit[i]  <= CMAX;
      end
      rr_ptr        <= '0;
      readEnable    <= 1'b0;
      readPort      <= '0;
      pendingEmpty  <= '1;
      errorOverflow <= 1'b0;
      errorCredit   <= 1'b0;
    end else begin
      for (int i = 0; i < nbrOfPorts; i++) begin
        pending[i] <= pending_nxt[i];
        credit[i]  <= credit_nxt[i];
      end
      rr_ptr       <= rr_nxt;
      readEnable   <= grant_valid;
      if (grant_valid) readPort <= grant_port;
      pendingEmpty <= empty_nxt;
      if (|ovf_hit) errorOverflow <= 1'b1;
      if (|crd_hit) errorCredit   <= 1'b1;
    end
  end

endmodule
